rst_sequencer: RTL

Reset sequencer for AlgolSoC. It sits downstream of the board-level reset synchronizer and its output is the clock-domain-synchronous `rst`. It merges that with a debounced push-button, a software reset request and a watchdog reset request. It releases three reset domains in a fixed order (memory, then peripherals, then core) and records the cause of the last reset.

---
 rtl/rst_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// Reset sequencer: merges POR, debounced button, software and watchdog requests, then
// releases memory, peripheral and core reset domains in order and records the last cause.
module rst_sequencer #(
   parameter int unsigned HOLD_CYCLES     = 16,
   parameter int unsigned STAGE_DELAY     = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_rst,
   input  logic       sw_rst_req,
   input  logic       wdt_rst_req,
   output logic       rst_mem,
   output logic       rst_periph,
   output logic       rst_core,
   output logic       ready,
   output logic [1:0] rst_cause
);

   localparam int unsigned MaxCycles = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
   localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
   localparam int unsigned DbW       = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYCLES - 1);
   localparam logic [CntW-1:0] StageLast = CntW'(STAGE_DELAY - 1);
   localparam logic [DbW-1:0]  DbMax     = DbW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {StHold, StRelMem, StRelPeriph, StRun} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic [DbW-1:0]  db_cnt_q, db_cnt_d;
   logic            btn_seen_q, btn_seen_d;
   logic            rst_mem_q, rst_mem_d;
   logic            rst_periph_q, rst_periph_d;
   logic            rst_core_q, rst_core_d;
   logic            ready_q, ready_d;
   logic [1:0]      rst_cause_q, rst_cause_d;

   logic btn_held;
   logic btn_first;
   logic src_active;

   always_comb begin
      sync1_d  = btn_rst;
      sync2_d  = sync1_q;
      db_cnt_d = db_cnt_q;
      if (!sync2_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q != DbMax) begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
      btn_held   = (db_cnt_q == DbMax);
      // Only the rising edge of btn_held counts as a new button cause.
      btn_first  = btn_held & ~btn_seen_q;
      btn_seen_d = btn_held;
      src_active = btn_held | sw_rst_req | wdt_rst_req;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      if (src_active) begin
         state_d = StHold;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StHold: begin
               if (cnt_q == HoldLast) begin
                  state_d = StRelMem;
                  cnt_d   = '0;
               end
            end
            StRelMem: begin
               if (cnt_q == StageLast) begin
                  state_d = StRelPeriph;
                  cnt_d   = '0;
               end
            end
            StRelPeriph: begin
               if (cnt_q == StageLast) begin
                  state_d = StRun;
                  cnt_d   = '0;
               end
            end
            StRun: begin
               cnt_d = '0;
            end
            default: begin
               state_d = StHold;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs are registered from the next state so they change on the transition edge.
      rst_mem_d    = (state_d == StHold);
      rst_periph_d = (state_d == StHold) || (state_d == StRelMem);
      rst_core_d   = (state_d != StRun);
      ready_d      = (state_d == StRun);

      rst_cause_d = rst_cause_q;
      if (wdt_rst_req) begin
         rst_cause_d = 2'd3;
      end else if (btn_first) begin
         rst_cause_d = 2'd1;
      end else if (sw_rst_req) begin
         rst_cause_d = 2'd2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StHold;
         cnt_q        <= '0;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         db_cnt_q     <= '0;
         btn_seen_q   <= 1'b0;
         rst_mem_q    <= 1'b1;
         rst_periph_q <= 1'b1;
         rst_core_q   <= 1'b1;
         ready_q      <= 1'b0;
         rst_cause_q  <= 2'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         db_cnt_q     <= db_cnt_d;
         btn_seen_q   <= btn_seen_d;
         rst_mem_q    <= rst_mem_d;
         rst_periph_q <= rst_periph_d;
         rst_core_q   <= rst_core_d;
         ready_q      <= ready_d;
         rst_cause_q  <= rst_cause_d;
      end
   end

   assign rst_mem    = rst_mem_q;
   assign rst_periph = rst_periph_q;
   assign rst_core   = rst_core_q;
   assign ready      = ready_q;
   assign rst_cause  = rst_cause_q;

endmodule
